// File: rtl/q_action_selector.sv
// Epsilon-greedy action selector: scans the four Q-values of the requested state,
// keeps the signed maximum, and optionally swaps it for an LFSR-chosen action.
module q_action_selector #(
    parameter int          Q_WIDTH     = 16,
    parameter int          STATE_WIDTH = 6,
    parameter int          EPS_WIDTH   = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic [STATE_WIDTH-1:0]        i_current_state,
    input  logic [EPS_WIDTH-1:0]          i_epsilon,
    output logic                          o_q_rd_en,
    output logic [STATE_WIDTH+1:0]        o_q_rd_addr,
    input  logic signed [Q_WIDTH-1:0]     i_q_rd_data,
    output logic [3:0]                    o_next_action,
    output logic                          o_action_valid,
    output logic                          o_explored,
    output logic                          o_busy
);

    localparam logic [15:0] LFSR_INIT = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DECIDE} state_t;

    state_t                     r_state, w_next;
    logic [15:0]                r_lfsr;
    logic [STATE_WIDTH-1:0]     r_state_l;
    logic [EPS_WIDTH-1:0]       r_eps_l;
    logic [EPS_WIDTH-1:0]       r_rand;
    logic [1:0]                 r_ridx;
    logic [1:0]                 r_k;
    logic                       r_rd_en;
    logic [STATE_WIDTH+1:0]     r_addr;
    logic                       r_rd_vld;
    logic [1:0]                 r_rd_idx;
    logic signed [Q_WIDTH-1:0]  r_max;
    logic [1:0]                 r_greedy;
    logic [3:0]                 r_action;
    logic                       r_valid;
    logic                       r_explored;
    logic                       r_busy;
    logic                       w_explore;
    logic [1:0]                 w_pick;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_en) w_next = S_READ;
            S_READ:   if (r_k == 2'd3) w_next = S_DRAIN;
            S_DRAIN:  w_next = S_DECIDE;
            S_DECIDE: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_lfsr <= LFSR_INIT;
        else       r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign w_explore = (r_rand < r_eps_l);
    assign w_pick    = w_explore ? r_ridx : r_greedy;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state_l  <= '0;
            r_eps_l    <= '0;
            r_rand     <= '0;
            r_ridx     <= '0;
            r_k        <= '0;
            r_rd_en    <= 1'b0;
            r_addr     <= '0;
            r_rd_vld   <= 1'b0;
            r_rd_idx   <= '0;
            r_max      <= '0;
            r_greedy   <= '0;
            r_action   <= '0;
            r_valid    <= 1'b0;
            r_explored <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid  <= 1'b0;
            // Read data trails the strobe by one cycle; track which index it belongs to.
            r_rd_vld <= r_rd_en;
            r_rd_idx <= r_addr[1:0];
            if (r_rd_vld && (r_rd_idx == 2'd0 || i_q_rd_data > r_max)) begin
                r_max    <= i_q_rd_data;
                r_greedy <= r_rd_idx;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_en) begin
                        r_state_l <= i_current_state;
                        r_eps_l   <= i_epsilon;
                        r_busy    <= 1'b1;
                        r_rd_en   <= 1'b1;
                        r_addr    <= {i_current_state, 2'd0};
                        r_k       <= 2'd0;
                    end
                end
                S_READ: begin
                    if (r_k == 2'd3) begin
                        r_rd_en <= 1'b0;
                    end else begin
                        r_k    <= r_k + 2'd1;
                        r_addr <= {r_state_l, r_k + 2'd1};
                    end
                end
                S_DRAIN: begin
                    r_rand <= r_lfsr[EPS_WIDTH-1:0];
                    r_ridx <= r_lfsr[9:8];
                end
                S_DECIDE: begin
                    r_action   <= 4'b0001 << w_pick;
                    r_explored <= w_explore;
                    r_valid    <= 1'b1;
                    r_busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_q_rd_en      = r_rd_en;
    assign o_q_rd_addr    = r_addr;
    assign o_next_action  = r_action;
    assign o_action_valid = r_valid;
    assign o_explored     = r_explored;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_q_action_selector.sv
// Directed bench for q_action_selector: table of greedy vectors, then timing,
// reset-abort and exploration sequences checked against a reference LFSR.
module tb_q_action_selector;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic [5:0]         current_state = '0;
    logic [7:0]         epsilon = '0;
    logic               q_rd_en;
    logic [7:0]         q_rd_addr;
    logic signed [15:0] q_rd_data = '0;
    logic [3:0]         next_action;
    logic               action_valid;
    logic               explored;
    logic               busy;

    q_action_selector dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_current_state(current_state),
        .i_epsilon(epsilon), .o_q_rd_en(q_rd_en), .o_q_rd_addr(q_rd_addr),
        .i_q_rd_data(q_rd_data), .o_next_action(next_action),
        .o_action_valid(action_valid), .o_explored(explored), .o_busy(busy)
    );

    always #5 clk = ~clk;

    logic signed [15:0] qmem [0:255];
    always @(posedge clk) if (q_rd_en) q_rd_data <= qmem[q_rd_addr];

    int         cyc = 0, rd_cnt = 0, av_cnt = 0;
    logic [7:0] rd_hist [0:3];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (q_rd_en) begin
            rd_hist[rd_cnt[1:0]] <= q_rd_addr;
            rd_cnt <= rd_cnt + 1;
        end
        if (action_valid) av_cnt <= av_cnt + 1;
    end

    // Reference LFSR; h2 holds the value present at the edge before the last one.
    logic [15:0] m_lfsr, h1, h2;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_lfsr <= 16'hACE1; h1 <= '0; h2 <= '0;
        end else begin
            h1 <= m_lfsr;
            h2 <= h1;
            m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
        end
    end

    int total = 0, bad = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic wait_av(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); @(negedge clk);
            if (action_valid) begin ok = 1'b1; break; end
        end
    endtask

    // One en pulse; inputs are scrambled right after acceptance.
    task automatic run_dec(input logic [5:0] st, input logic [7:0] eps, output int lat);
        current_state = st; epsilon = eps; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0; current_state = ~st; epsilon = 8'hFF;
        lat = 99;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); @(negedge clk);
            if (action_valid) begin lat = i; break; end
        end
    endtask

    typedef struct {
        logic [5:0]       st;
        logic [3:0][15:0] q;     // q[k] = Q(st, k)
        logic [3:0]       act;
    } vec_t;

    vec_t vecs [0:6];

    task automatic explore_run(input logic [7:0] eps, input int n, output int n_expl);
        bit         ok;
        logic       e_expl;
        logic [1:0] e_idx;
        n_expl = 0;
        current_state = 6'd7; epsilon = eps; en = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_av(20, ok);
            if (!ok) begin check("explore_timeout", 0, 1); break; end
            e_expl = (h2[7:0] < eps);
            e_idx  = e_expl ? h2[9:8] : 2'd3;
            check("explore_flag", explored, e_expl);
            check("explore_action", next_action, 4'b0001 << e_idx);
            if (explored) n_expl++;
        end
        en = 1'b0;
    endtask

    initial begin
        int  lat, base_rd, base_av, t0, n_expl, diff, tol;
        bit  ok;
        logic [7:0] eps_l [0:3];
        int  n_l [0:3];

        for (int i = 0; i < 256; i++) qmem[i] = 16'(i * 37 - 3000);
        vecs[0] = '{st: 6'd5,  q: {16'd7,    16'hFFFD, 16'd40,   16'd10  }, act: 4'b0010};
        vecs[1] = '{st: 6'd9,  q: {16'hFFCE, 16'hFFFB, 16'hFFFB, 16'hFF9C}, act: 4'b0010};
        vecs[2] = '{st: 6'd12, q: {16'd0,    16'd0,    16'h8000, 16'h7FFF}, act: 4'b0001};
        vecs[3] = '{st: 6'd63, q: {16'd0,    16'd0,    16'd0,    16'd0   }, act: 4'b0001};
        vecs[4] = '{st: 6'd0,  q: {16'd4,    16'd3,    16'd2,    16'd1   }, act: 4'b1000};
        vecs[5] = '{st: 6'd33, q: {16'h8001, 16'h8000, 16'h8000, 16'h8000}, act: 4'b1000};
        vecs[6] = '{st: 6'd20, q: {16'd6,    16'd6,    16'd5,    16'd5   }, act: 4'b0100};

        // reset state
        repeat (3) @(negedge clk);
        check("rst_rd_en", q_rd_en, 0);
        check("rst_rd_addr", q_rd_addr, 0);
        check("rst_action", next_action, 0);
        check("rst_valid", action_valid, 0);
        check("rst_explored", explored, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // greedy table
        foreach (vecs[v]) begin
            for (int k = 0; k < 4; k++) qmem[{vecs[v].st, 2'(k)}] = vecs[v].q[k];
            base_rd = rd_cnt;
            run_dec(vecs[v].st, 8'd0, lat);
            check("greedy_latency", lat, 6);
            check("greedy_action", next_action, vecs[v].act);
            check("greedy_explored", explored, 0);
            check("greedy_busy_low", busy, 0);
            check("greedy_reads", rd_cnt - base_rd, 4);
            for (int k = 0; k < 4; k++)
                check("greedy_addr", rd_hist[(base_rd + k) & 3], {vecs[v].st, 2'(k)});
            @(negedge clk);
            check("action_hold", next_action, vecs[v].act);
        end

        // en held through busy: one decision, four reads
        base_rd = rd_cnt; base_av = av_cnt;
        current_state = 6'd5; epsilon = 8'd0; en = 1'b1;
        @(posedge clk); #1;
        check("busy_high", busy, 1);
        repeat (5) @(posedge clk);
        #1 en = 1'b0;
        repeat (12) @(negedge clk);
        check("busy_single_valid", av_cnt - base_av, 1);
        check("busy_reads", rd_cnt - base_rd, 4);
        check("busy_action", next_action, 4'b0010);

        // en held high: decisions every 7 cycles
        current_state = 6'd9; en = 1'b1;
        wait_av(20, ok);
        check("b2b_first", ok, 1);
        for (int d = 0; d < 2; d++) begin
            t0 = cyc;
            wait_av(20, ok);
            check("b2b_period", cyc - t0, 7);
        end
        en = 1'b0;
        repeat (3) @(negedge clk);

        // reset in the third READ cycle aborts with no output
        base_av = av_cnt;
        current_state = 6'd0; epsilon = 8'd0; en = 1'b1;
        @(posedge clk); #1 en = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("abort_rd_en", q_rd_en, 0);
        check("abort_rd_addr", q_rd_addr, 0);
        check("abort_action", next_action, 0);
        check("abort_valid", action_valid, 0);
        check("abort_explored", explored, 0);
        check("abort_busy", busy, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("abort_no_valid", av_cnt - base_av, 0);
        run_dec(6'd5, 8'd0, lat);
        check("post_rst_latency", lat, 6);
        check("post_rst_action", next_action, 4'b0010);
        @(negedge clk);

        // exploration against the reference LFSR
        for (int k = 0; k < 4; k++) qmem[{6'd7, 2'(k)}] = 16'(k + 1);
        explore_run(8'd255, 1000, n_expl);
        check("eps255_mostly_explore", n_expl > 990, 1);
        repeat (3) @(negedge clk);

        eps_l = '{8'd0, 8'd64, 8'd128, 8'd255};
        n_l   = '{256, 4096, 4096, 256};
        for (int s = 0; s < 4; s++) begin
            explore_run(eps_l[s], n_l[s], n_expl);
            diff = n_expl * 256 - int'(eps_l[s]) * n_l[s];
            if (diff < 0) diff = -diff;
            tol = (3 * n_l[s] * 256) / 100;
            check("explore_rate", diff <= tol, 1);
            check("rate_onehot", $onehot(next_action), 1);
            repeat (3) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
